// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes used by bridge, interconnect and slaves,
// plus the master bridge state encoding.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StResp
  } bridge_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle connecting masters, the interconnect and slaves.
interface axi4_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import axi4_lite_pkg::*;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  resp_t                   bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  resp_t                   rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Turns single-outstanding core load/store requests into AXI4-Lite transactions and
// returns a one-cycle response pulse. All outputs except req_ready are registered.
module axi4_lite_master_bridge
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  axi4_lite_if.master             master_if
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  bridge_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign accept = (state_q == StIdle) && req_valid;
  assign aw_hs  = awvalid_q && master_if.awready;
  assign w_hs   = wvalid_q && master_if.wready;
  assign b_hs   = bready_q && master_if.bvalid;
  assign ar_hs  = arvalid_q && master_if.arready;
  assign r_hs   = rready_q && master_if.rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (req_valid) state_d = req_write ? StWrAddrData : StRdAddr;
      StWrAddrData: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWrResp;
      StWrResp:     if (b_hs) state_d = StResp;
      StRdAddr:     if (ar_hs) state_d = StRdData;
      StRdData:     if (r_hs) state_d = StResp;
      StResp:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wstrb_d = req_wstrb;
    end else if (state_d == StIdle) begin
      addr_d = '0;
    end
    aw_done_d    = (state_q == StWrAddrData) && (aw_done_q || aw_hs);
    w_done_d     = (state_q == StWrAddrData) && (w_done_q || w_hs);
    awvalid_d    = (state_d == StWrAddrData) && !aw_done_d;
    wvalid_d     = (state_d == StWrAddrData) && !w_done_d;
    bready_d     = (state_d == StWrResp);
    arvalid_d    = (state_d == StRdAddr);
    rready_d     = (state_d == StRdData);
    resp_valid_d = (state_d == StResp);
    if (b_hs) begin
      resp_rdata_d = '0;
      resp_err_d   = (master_if.bresp != OKAY);
    end
    if (r_hs) begin
      resp_rdata_d = master_if.rdata;
      resp_err_d   = (master_if.rresp != OKAY);
    end
  end

  assign req_ready         = (state_q == StIdle);
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_err          = resp_err_q;
  assign master_if.awvalid = awvalid_q;
  assign master_if.awaddr  = addr_q;
  assign master_if.wvalid  = wvalid_q;
  assign master_if.wdata   = wdata_q;
  assign master_if.wstrb   = wstrb_q;
  assign master_if.bready  = bready_q;
  assign master_if.arvalid = arvalid_q;
  assign master_if.araddr  = addr_q;
  assign master_if.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge: configurable slave, a transaction-level
// model checked every cycle, and hand-computed timing/data expectations.
module tb_axi4_lite_master_bridge;
  import axi4_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .master_if  (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave: READY after a per-channel delay; response one cycle after
  // the request is registered, plus cfg_*_lat extra wait cycles
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_lat = 0, cfg_r_lat = 0;
  resp_t       cfg_bresp = OKAY, cfg_rresp = OKAY;
  logic [31:0] cfg_rdata = '0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          got_aw, got_w, b_pend, r_pend;
  logic        s_aw_hs, s_w_hs, s_ar_hs;

  assign axi.awready = axi.awvalid && (aw_cnt == cfg_aw_dly);
  assign axi.wready  = axi.wvalid && (w_cnt == cfg_w_dly);
  assign axi.arready = axi.arvalid && (ar_cnt == cfg_ar_dly);
  assign axi.bresp   = cfg_bresp;
  assign axi.rresp   = cfg_rresp;
  assign axi.rdata   = cfg_rdata;
  assign s_aw_hs     = axi.awvalid && axi.awready;
  assign s_w_hs      = axi.wvalid && axi.wready;
  assign s_ar_hs     = axi.arvalid && axi.arready;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 0; got_w <= 0; b_pend <= 0; r_pend <= 0;
      axi.bvalid <= 1'b0;
      axi.rvalid <= 1'b0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
      if (s_aw_hs) got_aw <= 1;
      if (s_w_hs) got_w <= 1;
      if ((got_aw || s_aw_hs) && (got_w || s_w_hs) && (s_aw_hs || s_w_hs)) begin
        got_aw <= 0; got_w <= 0; b_pend <= 1; b_cnt <= 0;
      end
      if (b_pend) begin
        if (b_cnt == cfg_b_lat) begin axi.bvalid <= 1'b1; b_pend <= 0; end
        else b_cnt <= b_cnt + 1;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (s_ar_hs) begin r_pend <= 1; r_cnt <= 0; end
      if (r_pend) begin
        if (r_cnt == cfg_r_lat) begin axi.rvalid <= 1'b1; r_pend <= 0; end
        else r_cnt <= r_cnt + 1;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  // ---------------- transaction-level model: one request in flight; each channel's
  // VALID/READY follows from which handshakes have been seen; response one cycle later
  bit          m_on, busy, seen_aw, seen_w, seen_ar, resp_due;
  bit          cur_wr, exp_err;
  logic [31:0] cur_addr, cur_wdata, exp_rdata;
  logic [3:0]  cur_strb;

  always @(negedge clk) begin : model
    bit e_aw, e_w, e_ar, e_b, e_r, nxt_due;
    e_aw = busy && cur_wr && !seen_aw;
    e_w  = busy && cur_wr && !seen_w;
    e_ar = busy && !cur_wr && !seen_ar;
    e_b  = busy && cur_wr && seen_aw && seen_w && !resp_due;
    e_r  = busy && !cur_wr && seen_ar && !resp_due;
    if (m_on) begin
      chk("m_req_ready", req_ready, !busy);
      chk("m_resp_valid", resp_valid, resp_due);
      if (resp_due) begin
        chk("m_resp_err", resp_err, exp_err);
        chk("m_resp_rdata", resp_rdata, exp_rdata);
      end
      chk("m_awvalid", axi.awvalid, e_aw);
      chk("m_wvalid", axi.wvalid, e_w);
      chk("m_arvalid", axi.arvalid, e_ar);
      chk("m_bready", axi.bready, e_b);
      chk("m_rready", axi.rready, e_r);
      if (!busy) chk("m_idle_addr", {axi.awaddr, axi.araddr}, 64'h0);
      else if (!resp_due) chk("m_addr", cur_wr ? axi.awaddr : axi.araddr, cur_addr);
      if (e_w) chk("m_wdata_wstrb", {axi.wdata, axi.wstrb}, {cur_wdata, cur_strb});
    end
    if (rst) begin
      m_on = 1; busy = 0; resp_due = 0; seen_aw = 0; seen_w = 0; seen_ar = 0;
    end else if (m_on) begin
      nxt_due = 0;
      if (resp_due) begin
        busy = 0;
      end else if (busy) begin
        if (e_aw && axi.awready) seen_aw = 1;
        if (e_w && axi.wready) seen_w = 1;
        if (e_ar && axi.arready) seen_ar = 1;
        if (e_b && axi.bvalid) begin
          nxt_due = 1; exp_err = (axi.bresp != OKAY); exp_rdata = '0;
        end
        if (e_r && axi.rvalid) begin
          nxt_due = 1; exp_err = (axi.rresp != OKAY); exp_rdata = axi.rdata;
        end
      end else if (req_valid) begin
        busy = 1; seen_aw = 0; seen_w = 0; seen_ar = 0;
        cur_wr = req_write; cur_addr = req_addr; cur_wdata = req_wdata; cur_strb = req_wstrb;
      end
      resp_due = nxt_due;
    end
  end

  // ---------------- stimulus helpers
  task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
  endtask

  task automatic wait_accept(output int c);
    c = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready && req_valid) begin c = cyc; break; end
    end
    if (c < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no req_ready within 20 cycles, expected acceptance");
    end
  endtask

  task automatic wait_resp(output int c, output logic [31:0] rd, output logic er);
    c = -1; rd = '0; er = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid) begin c = cyc; rd = resp_rdata; er = resp_err; break; end
    end
    if (c < 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid within 40 cycles, expected a response");
    end
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test by 100000 time units, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          a1, r1, a2, r2;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  skew_exp [1:5];
    skew_exp = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 34'h0);
    chk("rst_valids_readies",
        {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'h0);
    chk("rst_addrs", {axi.awaddr, axi.araddr}, 64'h0);
    chk("rst_wdata_wstrb", {axi.wdata, axi.wstrb}, 36'h0);

    // Store, zero-wait slave
    drive(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_accept(a1);
    release_req();
    @(negedge clk);
    chk("store_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
    chk("store_awaddr", axi.awaddr, 32'h10);
    wait_resp(r1, rd, er);
    chk("store_latency", r1 - a1, 4);
    chk("store_err", er, 1'b0);
    chk("store_rdata", rd, 32'h0);

    // Skewed write: AW accepted at N+1, W at N+4
    cfg_w_dly = 3;
    drive(1, 32'h0000_0010, 32'h0102_0304, 4'h5);
    wait_accept(a1);
    release_req();
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      chk($sformatf("skew_valids_n%0d", k), {axi.awvalid, axi.wvalid}, skew_exp[k]);
      if (k == 4) chk("skew_wready_n4", axi.wready, 1'b1);
      if (k == 5) chk("skew_awaddr_n5", axi.awaddr, 32'h10);
    end
    wait_resp(r1, rd, er);
    chk("skew_latency", r1 - a1, 7);
    cfg_w_dly = 0;

    // Load with 3 extra RVALID wait cycles
    cfg_r_lat = 3;
    cfg_rdata = 32'h1234_5678;
    drive(0, 32'h0000_0020, 32'h0, 4'h0);
    wait_accept(a1);
    release_req();
    wait_resp(r1, rd, er);
    chk("load_latency", r1 - a1, 7);
    chk("load_rdata", rd, 32'h1234_5678);
    chk("load_err", er, 1'b0);
    cfg_r_lat = 0;

    // Unmapped address: DECERR on R, data still returned
    cfg_rresp = DECERR;
    cfg_rdata = 32'hA5A5_0001;
    drive(0, 32'hF000_0000, 32'h0, 4'h0);
    wait_accept(a1);
    release_req();
    wait_resp(r1, rd, er);
    chk("decerr_err", er, 1'b1);
    chk("decerr_rdata", rd, 32'hA5A5_0001);
    chk("decerr_latency", r1 - a1, 4);
    cfg_rresp = OKAY;
    drive(1, 32'h0000_0014, 32'h0BAD_F00D, 4'h3);
    wait_accept(a1);
    release_req();
    wait_resp(r1, rd, er);
    chk("after_decerr_latency", r1 - a1, 4);
    chk("after_decerr_err", er, 1'b0);

    // SLVERR on B: error flagged, store data reads as zero
    cfg_bresp = SLVERR;
    drive(1, 32'h0000_0018, 32'hFFFF_FFFF, 4'hF);
    wait_accept(a1);
    release_req();
    wait_resp(r1, rd, er);
    chk("slverr_err", er, 1'b1);
    chk("slverr_rdata", rd, 32'h0);
    cfg_bresp = OKAY;

    // Reset while waiting in WR_RESP
    cfg_b_lat = 6;
    drive(1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
    wait_accept(a1);
    release_req();
    a2 = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (axi.bready) begin a2 = n; break; end
    end
    if (a2 < 0) begin
      checks++; errors++;
      $display("FAIL bready_timeout: got no BREADY within 20 cycles, expected WR_RESP");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_bready", axi.bready, 1'b0);
    chk("rstmid_awaddr", axi.awaddr, 32'h0);
    chk("rstmid_req_ready", req_ready, 1'b1);
    chk("rstmid_resp_valid", resp_valid, 1'b0);
    repeat (10) @(negedge clk);
    cfg_b_lat = 0;

    // Back-to-back: store then load with req_valid held high
    cfg_rdata = 32'hCAFE_0044;
    drive(1, 32'h0000_0040, 32'h1122_3344, 4'hF);
    wait_accept(a1);
    @(posedge clk);
    #1;
    req_write = 1'b0; req_addr = 32'h0000_0044; req_wdata = '0; req_wstrb = '0;
    wait_resp(r1, rd, er);
    wait_accept(a2);
    release_req();
    wait_resp(r2, rd, er);
    chk("b2b_ready_after_resp", a2, r1 + 1);
    chk("b2b_interval", a2 - a1, 5);
    chk("b2b_load_latency", r2 - a2, 4);
    chk("b2b_load_rdata", rd, 32'hCAFE_0044);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
